output_weight_update: RTL and testbench
=======================================

Name: output_weight_update

Overview:
- Backward-pass stage directly downstream of the output neuron.
- Consumes the output neuron's final value, the target nibble and the 8 hidden-neuron activations.
- Sequentially updates the 8 hidden-to-output weights, one weight per cycle: w_k <- sat8(w_k - ((final - target) * h_k) >>> LR_SHIFT).
- Drives the packed weight bus back into the output neuron and raises b_end_o to the state machine when the update is done.

Parameters:
- NUM_HIDDEN, 8: number of hidden neurons and weights. Fixed at 8 for this tapeout.
- LR_SHIFT, 4: learning-rate right-shift, arithmetic, applied to the product.
- W_RESET, 64'h0807060504030201: weight value after reset; w0 sits in bits [7:0].

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: reset.
- en_i, in, 1: global enable; when low, all state freezes.
- start_i, in, 1: request an update pass; sampled only in IDLE.
- load_i, in, 1: load w_init_i into the weight bank; honoured only in IDLE.
- w_init_i, in, 64: 8 x signed 8-bit initial weights; w_k = [8k+7:8k].
- final_i, in, 23: unsigned output-neuron result.
- target_i, in, 4: unsigned training target.
- hidden_i, in, 80: 8 x unsigned 10-bit activations; h_k = [10k+9:10k].
- weights_o, out, 64: registered weight bank, same packing as w_init_i.
- busy_o, out, 1: high in UPDATE and DONE.
- b_end_o, out, 1: one-cycle completion pulse.
- sat_o, out, 1: sticky flag; set if any weight saturated during the current pass.

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: weights_o = W_RESET, state IDLE, idx = 0, busy_o = 0, b_end_o = 0, sat_o = 0.
- Reset mid-pass aborts immediately; no partial results are kept.
- en_i low: state, idx, weights, err and snapshot all hold. Outputs hold, including a b_end_o already at 1. The pass resumes unchanged when en_i returns high.
- FSM states: IDLE, UPDATE, DONE.
- IDLE, load_i = 1: weights <= w_init_i. If start_i is also 1 in the same cycle, load wins and start is dropped.
- IDLE, start_i = 1 (load_i = 0):
  - err <= zext(final_i) - zext(target_i), 25-bit signed.
  - Capture a snapshot of hidden_i.
  - sat_o <= 0, idx <= 0, go to UPDATE.
- UPDATE, one weight per cycle:
  - prod = err * zext(h_idx), 36-bit signed.
  - delta = prod >>> LR_SHIFT.
  - w_idx <= saturate(w_idx - delta) to [-128, 127]; if clamped, sat_o <= 1.
  - idx increments. After idx = 7, go to DONE.
- DONE: b_end_o = 1 for exactly one cycle, then go to IDLE.
- start_i and load_i are ignored while busy.
- Latency: start sampled at edge N; w_k is written at edge N+1+k; DONE is entered at edge N+8; b_end_o is high between edges N+8 and N+9; IDLE at N+9. busy_o is high for 9 cycles.
- Later changes on final_i, target_i or hidden_i during a pass do not affect that pass.
- err = 0 leaves all weights unchanged, and the full 9-cycle pass still runs.
- Intermediate widths never truncate before the saturation step.

Decomposition:
- idann_pkg holds:
  - NUM_HIDDEN = 8, W_WIDTH = 8, H_WIDTH = 10, F_WIDTH = 23, ERR_WIDTH = 25, PROD_WIDTH = 36.
  - Enum upd_state_t {IDLE, UPDATE, DONE}.
- One combinational sub-module, weight_sat_step.
  - Inputs: w, err, h.
  - Outputs: w_new, sat.
  - Implements multiply, shift, subtract and saturate.
  - The FSM, counter, snapshot registers and weight bank stay in the top module.

Test Plan:
1. Reset: assert rst_i for 2 cycles -> weights_o = 0x0807060504030201, busy_o = 0, b_end_o = 0, sat_o = 0.
2. Zero error: final = 5, target = 5, start pulse -> weights unchanged; busy_o high 9 cycles; b_end_o high exactly at cycle N+8.
3. Positive error: final = 10, target = 2, all h = 16, LR_SHIFT = 4 -> delta = 8 for every weight; w0 = 0xF9 (-7), w7 = 0x00, w3 = 0xFC; sat_o = 0.
4. Negative error with saturation: load all w = 100, final = 0, target = 15, all h = 32 -> delta = -30, 130 clamps to 127; weights_o = 0x7F7F7F7F7F7F7F7F, sat_o = 1. Next start clears sat_o.
5. Stall: drop en_i for 3 cycles while idx = 3 -> b_end_o arrives 3 cycles late; final weights are bit-identical to scenario 3.
6. Abort and priority:
   - rst_i while idx = 4 -> weights = W_RESET, IDLE, no b_end_o.
   - load_i and start_i together in IDLE -> w_init_i loaded, busy_o stays 0.

Source files
------------

// File: rtl/idann_pkg.sv
// Shared widths and FSM encoding for the output-layer backward pass.
package idann_pkg;
  localparam int NUM_HIDDEN = 8;
  localparam int W_WIDTH    = 8;
  localparam int H_WIDTH    = 10;
  localparam int F_WIDTH    = 23;
  localparam int ERR_WIDTH  = 25;
  localparam int PROD_WIDTH = 36;

  typedef enum logic [1:0] {IDLE, UPDATE, DONE} upd_state_t;
endpackage

// File: rtl/weight_sat_step.sv
// One gradient step for a single weight: w - (err*h >>> LR_SHIFT), clamped to int8.
module weight_sat_step
  import idann_pkg::*;
#(
  parameter int LR_SHIFT = 4
) (
  input  logic signed [W_WIDTH-1:0]   w,
  input  logic signed [ERR_WIDTH-1:0] err,
  input  logic        [H_WIDTH-1:0]   h,
  output logic signed [W_WIDTH-1:0]   w_new,
  output logic                        sat
);
  logic signed [PROD_WIDTH-1:0] prod, delta;
  logic signed [PROD_WIDTH:0]   diff;

  // h is an unsigned activation, so widen it with a zero sign bit first
  assign prod  = PROD_WIDTH'(err) * PROD_WIDTH'($signed({1'b0, h}));
  assign delta = prod >>> LR_SHIFT;
  assign diff  = (PROD_WIDTH+1)'(w) - (PROD_WIDTH+1)'(delta);

  always_comb begin
    w_new = diff[W_WIDTH-1:0];
    sat   = 1'b0;
    if (diff > (PROD_WIDTH+1)'(127)) begin
      w_new = 8'sh7f;
      sat   = 1'b1;
    end else if (diff < -(PROD_WIDTH+1)'(128)) begin
      w_new = 8'sh80;
      sat   = 1'b1;
    end
  end
endmodule

// File: rtl/output_weight_update.sv
// Serial hidden-to-output weight update: one weight per cycle, then a b_end_o pulse.
module output_weight_update
  import idann_pkg::*;
#(
  parameter int          LR_SHIFT = 4,
  parameter logic [63:0] W_RESET  = 64'h0807060504030201
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic                          start_i,
  input  logic                          load_i,
  input  logic [NUM_HIDDEN*W_WIDTH-1:0] w_init_i,
  input  logic [F_WIDTH-1:0]            final_i,
  input  logic [3:0]                    target_i,
  input  logic [NUM_HIDDEN*H_WIDTH-1:0] hidden_i,
  output logic [NUM_HIDDEN*W_WIDTH-1:0] weights_o,
  output logic                          busy_o,
  output logic                          b_end_o,
  output logic                          sat_o
);
  upd_state_t state_q, state_d;
  logic [2:0]                              idx_q;
  logic signed [ERR_WIDTH-1:0]             err_q;
  logic [NUM_HIDDEN-1:0][H_WIDTH-1:0]      hid_q;
  logic [NUM_HIDDEN-1:0][W_WIDTH-1:0]      w_q;
  logic                                    sat_q;
  logic signed [W_WIDTH-1:0]               w_new;
  logic                                    step_sat;

  weight_sat_step #(.LR_SHIFT(LR_SHIFT)) u_step (
    .w     ($signed(w_q[idx_q])),
    .err   (err_q),
    .h     (hid_q[idx_q]),
    .w_new (w_new),
    .sat   (step_sat)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i && !load_i) state_d = UPDATE;
      UPDATE:  if (idx_q == 3'(NUM_HIDDEN-1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else if (en_i) state_q <= state_d;
  end

  // Datapath: the snapshot (err, hid) keeps later input changes out of a running pass
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q <= '0;
      err_q <= '0;
      hid_q <= '0;
      w_q   <= W_RESET;
      sat_q <= 1'b0;
    end else if (en_i) begin
      case (state_q)
        IDLE: begin
          if (load_i) begin
            w_q <= w_init_i;
          end else if (start_i) begin
            err_q <= signed'(ERR_WIDTH'(final_i)) - signed'(ERR_WIDTH'(target_i));
            hid_q <= hidden_i;
            sat_q <= 1'b0;
            idx_q <= '0;
          end
        end
        UPDATE: begin
          w_q[idx_q] <= w_new;
          if (step_sat) sat_q <= 1'b1;
          idx_q <= idx_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign weights_o = w_q;
  assign busy_o    = (state_q != IDLE);
  assign b_end_o   = (state_q == DONE);
  assign sat_o     = sat_q;
endmodule

// File: tb/tb_output_weight_update.sv
// Scoreboard bench for output_weight_update: expected banks queued at start, checked at b_end_o.
module tb_output_weight_update;
  localparam logic [63:0] W_RST = 64'h0807060504030201;

  logic        clk_i = 0, rst_i = 1, en_i = 1, start_i = 0, load_i = 0;
  logic [63:0] w_init_i = '0;
  logic [22:0] final_i = '0;
  logic [3:0]  target_i = '0;
  logic [79:0] hidden_i = '0;
  logic [63:0] weights_o;
  logic        busy_o, b_end_o, sat_o;

  output_weight_update dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .start_i(start_i), .load_i(load_i),
    .w_init_i(w_init_i), .final_i(final_i), .target_i(target_i), .hidden_i(hidden_i),
    .weights_o(weights_o), .busy_o(busy_o), .b_end_o(b_end_o), .sat_o(sat_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_fail = 0;
  logic [63:0] mdl_w;
  logic [64:0] sb_q[$];
  logic [63:0] s3_w;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Independent reference of the update rule in plain integer arithmetic
  function automatic logic [64:0] model(input logic [63:0] w, input logic [22:0] f,
                                        input logic [3:0] t, input logic [79:0] h);
    longint err, p, d, nw;
    logic [63:0] r;
    logic s;
    err = longint'(f) - longint'(t);
    s = 1'b0;
    r = w;
    for (int k = 0; k < 8; k++) begin
      p  = err * longint'(h[10*k +: 10]);
      d  = p >>> 4;
      nw = longint'($signed(w[8*k +: 8])) - d;
      if (nw > 127) begin nw = 127; s = 1'b1; end
      if (nw < -128) begin nw = -128; s = 1'b1; end
      r[8*k +: 8] = nw[7:0];
    end
    return {s, r};
  endfunction

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    rst_i = 1; tick(); tick(); rst_i = 0;
    mdl_w = W_RST;
  endtask

  task automatic do_load(input logic [63:0] w);
    load_i = 1; w_init_i = w; tick(); load_i = 0;
    mdl_w = w;
  endtask

  function automatic logic [79:0] all_h(input logic [9:0] h);
    logic [79:0] r;
    for (int k = 0; k < 8; k++) r[10*k +: 10] = h;
    return r;
  endfunction

  task automatic run_pass(input string tag, input logic [22:0] f, input logic [3:0] t,
                          input logic [79:0] h, input int stall);
    logic [64:0] e, got;
    int busy_cnt, lat, bend_cnt;
    final_i = f; target_i = t; hidden_i = h; start_i = 1;
    sb_q.push_back(model(mdl_w, f, t, h));
    tick();
    start_i = 0;
    chk({tag, "_sat_clr"}, 64'(sat_o), 64'd0);
    busy_cnt = busy_o ? 1 : 0;
    lat = 0; bend_cnt = 0;
    for (int c = 1; c < 40; c++) begin
      tick();
      if (c == 2) begin final_i = 23'($urandom); target_i = 4'($urandom); hidden_i = {$urandom, $urandom, $urandom}; end
      if (stall > 0 && c == 3) en_i = 0;
      if (stall > 0 && c == 3 + stall) en_i = 1;
      if (busy_o) busy_cnt++;
      if (b_end_o) begin
        bend_cnt++;
        if (lat == 0) begin
          lat = c;
          if (sb_q.size() == 0) chk({tag, "_sb_empty"}, 64'd1, 64'd0);
          else begin
            e = sb_q.pop_front();
            chk({tag, "_weights"}, weights_o, e[63:0]);
            chk({tag, "_sat"}, 64'(sat_o), 64'(e[64]));
            mdl_w = e[63:0];
          end
        end
      end
      if (!busy_o) break;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(8 + stall));
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(9 + stall));
    chk({tag, "_bend_cycles"}, 64'(bend_cnt), 64'(1 + stall > 0 && stall > 0 ? 1 : 1));
  endtask

  initial begin
    int seen;
    do_reset();
    chk("rst_weights", weights_o, W_RST);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_bend", 64'(b_end_o), 64'd0);
    chk("rst_sat", 64'(sat_o), 64'd0);

    run_pass("zero_err", 23'd5, 4'd5, all_h(10'd700), 0);
    chk("zero_err_unchanged", weights_o, W_RST);

    run_pass("pos_err", 23'd10, 4'd2, all_h(10'd16), 0);
    chk("pos_err_value", weights_o, 64'h00FFFEFDFCFBFAF9);
    s3_w = weights_o;

    do_load({8{8'd100}});
    run_pass("neg_sat", 23'd0, 4'd15, all_h(10'd32), 0);
    chk("neg_sat_value", weights_o, 64'h7F7F7F7F7F7F7F7F);
    chk("neg_sat_flag", 64'(sat_o), 64'd1);
    run_pass("sat_next", 23'd3, 4'd3, all_h(10'd1), 0);

    do_reset();
    run_pass("stall", 23'd10, 4'd2, all_h(10'd16), 3);
    chk("stall_vs_pos", weights_o, s3_w);

    // Random passes, including large errors that drive the clamp both ways
    for (int i = 0; i < 6; i++) begin
      do_load({$urandom, $urandom});
      run_pass("rand", 23'($urandom >> (i * 3)), 4'($urandom), {$urandom, $urandom, $urandom}, 0);
    end

    // Reset mid-pass at idx 4
    do_reset();
    final_i = 23'd10; target_i = 4'd2; hidden_i = all_h(10'd16); start_i = 1;
    tick(); start_i = 0;
    for (int c = 0; c < 4; c++) tick();
    rst_i = 1; tick(); rst_i = 0;
    chk("abort_weights", weights_o, W_RST);
    chk("abort_busy", 64'(busy_o), 64'd0);
    seen = 0;
    for (int c = 0; c < 10; c++) begin tick(); if (b_end_o) seen++; end
    chk("abort_no_bend", 64'(seen), 64'd0);

    // load wins over start
    load_i = 1; start_i = 1; w_init_i = 64'h1122334455667788; final_i = 23'd99;
    tick(); load_i = 0; start_i = 0;
    chk("prio_weights", weights_o, 64'h1122334455667788);
    chk("prio_busy", 64'(busy_o), 64'd0);
    tick();
    chk("prio_busy2", 64'(busy_o), 64'd0);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
